st7789_pixel_cmd_gen: RTL

Consumes the per-pixel stream (x, y, RGB565 colour) produced by the glyph writer stage and converts each pixel into an ST7789 command/data byte sequence: CASET window, RASET window, RAMWR, colour. Its output feeds the SPI byte serializer through a valid/ready handshake. A small pixel FIFO absorbs bursts from the upstream stage. Redundant CASET/RASET sequences are skipped when the column or row matches the previous pixel.

---
 rtl/st7789_pixel_cmd_gen.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/st7789_pixel_cmd_gen.sv
// st7789_pixel_cmd_gen
//   Turns a stream of (x, y, RGB565) pixels into ST7789 command/data bytes:
//   CASET window, RASET window, RAMWR, colour. A pixel FIFO absorbs upstream
//   bursts; CASET/RASET are skipped when column/row repeat the previous pixel.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pix_valid       pixel present on pix_x/pix_y/pix_color
//   pix_x, pix_y    pixel column / row (10 bits)
//   pix_color       RGB565 colour
//   pix_ready       FIFO not full
//   byte_valid      byte_data/byte_dc valid
//   byte_data       byte to serializer
//   byte_dc         0 = command, 1 = data
//   byte_ready      serializer accepts byte this cycle
//   busy            FIFO non-empty or sequence in progress
//   ovf             sticky: pixel dropped on full FIFO
//   oob             sticky: out-of-range pixel discarded
module st7789_pixel_cmd_gen #(
    parameter int unsigned SCREEN_W   = 240,
    parameter int unsigned SCREEN_H   = 320,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [15:0] pix_color,
    output logic        pix_ready,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    input  logic        byte_ready,
    output logic        busy,
    output logic        ovf,
    output logic        oob
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [9:0]  W_LIM     = 10'(SCREEN_W);
    localparam logic [9:0]  H_LIM     = 10'(SCREEN_H);

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        IDLE, LOAD, CASET_C, CASET_D, RASET_C, RASET_D, RAMWR_C, COLOR_D
    } state_t;

    state_t state;

    // ---------------------------------------------------------------- FIFO
    logic [35:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          wr_en;
    logic          rd_en;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    // full is taken from the registered count, so a pop in the same cycle
    // never makes room for a write.
    assign wr_en     = pix_valid && !full;
    assign rd_en     = (state == IDLE) && !empty;
    assign pix_ready = !full;
    assign busy      = (state != IDLE) || !empty;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {pix_x, pix_y, pix_color};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pix_valid && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------ sequencer
    logic [9:0]  cur_x;
    logic [9:0]  cur_y;
    logic [15:0] cur_color;
    logic [9:0]  last_x;
    logic [9:0]  last_y;
    logic        xv;
    logic        yv;
    logic [1:0]  idx;
    logic        xfer;
    logic        need_x;
    logic        need_y;

    assign xfer   = byte_valid && byte_ready;
    assign need_x = !xv || (cur_x != last_x);
    assign need_y = !yv || (cur_y != last_y);

    // Window bytes: start hi, start lo, end hi, end lo (start == end).
    function automatic logic [7:0] coord_byte(input logic [9:0] v, input logic [1:0] i);
        return i[0] ? v[7:0] : {6'b0, v[9:8]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            cur_color  <= '0;
            last_x     <= '0;
            last_y     <= '0;
            xv         <= 1'b0;
            yv         <= 1'b0;
            idx        <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            byte_dc    <= 1'b0;
            oob        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {cur_x, cur_y, cur_color} <= mem[rd_ptr];
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (cur_x >= W_LIM || cur_y >= H_LIM) begin
                        oob   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        byte_valid <= 1'b1;
                        byte_dc    <= 1'b0;
                        if (need_x) begin
                            byte_data <= CMD_CASET;
                            state     <= CASET_C;
                        end else if (need_y) begin
                            byte_data <= CMD_RASET;
                            state     <= RASET_C;
                        end else begin
                            byte_data <= CMD_RAMWR;
                            state     <= RAMWR_C;
                        end
                    end
                end
                CASET_C: begin
                    if (xfer) begin
                        byte_data <= coord_byte(cur_x, 2'd0);
                        byte_dc   <= 1'b1;
                        idx       <= '0;
                        state     <= CASET_D;
                    end
                end
                CASET_D: begin
                    if (xfer) begin
                        if (idx == 2'd3) begin
                            last_x  <= cur_x;
                            xv      <= 1'b1;
                            byte_dc <= 1'b0;
                            if (need_y) begin
                                byte_data <= CMD_RASET;
                                state     <= RASET_C;
                            end else begin
                                byte_data <= CMD_RAMWR;
                                state     <= RAMWR_C;
                            end
                        end else begin
                            idx       <= idx + 2'd1;
                            byte_data <= coord_byte(cur_x, idx + 2'd1);
                        end
                    end
                end
                RASET_C: begin
                    if (xfer) begin
                        byte_data <= coord_byte(cur_y, 2'd0);
                        byte_dc   <= 1'b1;
                        idx       <= '0;
                        state     <= RASET_D;
                    end
                end
                RASET_D: begin
                    if (xfer) begin
                        if (idx == 2'd3) begin
                            last_y    <= cur_y;
                            yv        <= 1'b1;
                            byte_dc   <= 1'b0;
                            byte_data <= CMD_RAMWR;
                            state     <= RAMWR_C;
                        end else begin
                            idx       <= idx + 2'd1;
                            byte_data <= coord_byte(cur_y, idx + 2'd1);
                        end
                    end
                end
                RAMWR_C: begin
                    if (xfer) begin
                        byte_data <= cur_color[15:8];
                        byte_dc   <= 1'b1;
                        idx       <= '0;
                        state     <= COLOR_D;
                    end
                end
                COLOR_D: begin
                    if (xfer) begin
                        if (idx == 2'd0) begin
                            byte_data <= cur_color[7:0];
                            idx       <= 2'd1;
                        end else begin
                            byte_valid <= 1'b0;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
